// File: rtl/ser8_pkg.sv
// Shared definitions for the 8-bit serializer: frame constants, FSM state type
// and the counter-to-bit-index mapping used for both bit orders.
package ser8_pkg;

    localparam int FRAME_BITS = 8;
    localparam int GAP_W      = 4;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    // Map the frame position to the data bit being sent.
    function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] cnt,
                                                   input bit               lsb_first);
        return lsb_first ? cnt : CNT_W'(FRAME_BITS - 1) - cnt;
    endfunction

endpackage

// File: rtl/bitsel8.sv
// Purely combinational 8:1 bit selector feeding the serial output.
module bitsel8 (
    input  logic [7:0] data,
    input  logic [2:0] sel,
    output logic       y
);

    assign y = data[sel];

endmodule

// File: rtl/ser8_tx.sv
// Byte-to-bit serializer with valid/ready on both sides, selectable bit order
// and an optional idle gap after every frame.
module ser8_tx
    import ser8_pkg::*;
#(
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic [CNT_W-1:0] sel,
    output logic             busy
);

    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP != 0) ? GAP_W'(GAP - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             last_bit;
    logic             byte_xfer;
    logic             bit_xfer;
    logic             sel_bit;

    assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(FRAME_BITS - 1));
    assign sel       = bit_index(cnt_q, LSB_FIRST);
    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_out   = ser_valid & sel_bit;
    assign ser_last  = last_bit;
    assign busy      = (state_q != ST_IDLE);
    // Without a gap, the final bit's transfer cycle also accepts the next byte.
    assign in_ready  = (state_q == ST_IDLE) || ((GAP == 0) && last_bit && ser_ready);
    assign byte_xfer = in_valid && in_ready;
    assign bit_xfer  = ser_valid && ser_ready;

    bitsel8 u_bitsel (
        .data (data_q),
        .sel  (sel),
        .y    (sel_bit)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                if (bit_xfer) begin
                    if (!last_bit) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (GAP != 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        // A captured byte overrides the end-of-frame decision (back-to-back frames).
        if (byte_xfer) begin
            data_d  = in_data;
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: doc/ser8_tx.md
SER8_TX -- requirements
Module: ser8_tx

Interface
REQ-001 Parameter LSB_FIRST, default 1; 1 = bit 0 sent first, 0 = bit 7 sent first.
REQ-002 Parameter GAP, default 0, range 0..15; idle cycles inserted after each frame's last bit.
REQ-003 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 in_data  input  8  parallel byte to serialize.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 ser_out  output  1  current serial bit.
REQ-009 ser_valid  output  1  ser_out is valid.
REQ-010 ser_last  output  1  ser_out is the 8th bit of the frame.
REQ-011 ser_ready  input  1  downstream accepts ser_out this cycle.
REQ-012 sel  output  3  index of the data bit currently on ser_out (debug/observability).
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States: IDLE, SHIFT, GAP, encoded as a shared enum.
REQ-015 Byte transfer occurs on a clk edge with in_valid && in_ready; a bit transfer occurs on a clk edge with ser_valid && ser_ready.
REQ-016 In IDLE, in_ready = 1, ser_valid = 0, ser_out = 0, ser_last = 0.
REQ-017 On a byte transfer, the block captures in_data into data_q, enters SHIFT and sets cnt = 0.
REQ-018 sel = cnt when LSB_FIRST = 1; sel = 7 - cnt when LSB_FIRST = 0.
REQ-019 In SHIFT, ser_valid = 1 and ser_out = data_q[sel], selected combinationally; first bit appears the cycle after the byte transfer (latency 1).
REQ-020 ser_last = 1 only when the state is SHIFT and cnt = 7.
REQ-021 With ser_ready = 0, ser_out, sel, cnt and data_q hold unchanged.
REQ-022 On a bit transfer with cnt < 7, cnt increments by 1.
REQ-023 On a bit transfer with cnt = 7 and GAP > 0: next state is GAP, gap counter loads GAP - 1.
REQ-024 On a bit transfer with cnt = 7 and GAP = 0: in_ready = 1 in that same cycle; a simultaneous byte transfer reloads data_q with cnt = 0 and stays in SHIFT (back-to-back, no bubble); otherwise next state is IDLE.
REQ-025 In SHIFT, in_ready = 0 except as stated in REQ-024.
REQ-026 In GAP: ser_valid = 0 and in_ready = 0; the gap counter decrements each cycle; when it reaches 0, next state is IDLE.
REQ-027 in_data changes while in SHIFT do not affect the frame in flight.
REQ-028 cnt is 3 bits; it never wraps except through the reload in REQ-017/024.

Reset
REQ-029 rst_n = 0 at a clk edge forces IDLE, cnt = 0, data_q = 0, gap counter = 0; outputs settle to in_ready = 1, ser_valid = 0, ser_last = 0, ser_out = 0, sel = (LSB_FIRST ? 0 : 7), busy = 0.
REQ-030 A reset asserted mid-frame discards the frame; no further bits of it are emitted after rst_n returns high.
REQ-031 rst_n has no effect between clock edges.

Structure
REQ-032 The state enum and the constants FRAME_BITS = 8 and GAP_W = 4 belong in the shared package ser8_pkg.
REQ-033 The 8:1 bit select is one sub-module, bitsel8 (inputs: 8-bit data, 3-bit sel; output: 1 bit; purely combinational); everything else is in ser8_tx.

Verification
REQ-034 LSB_FIRST = 1, GAP = 0, in_data = 8'hA5, ser_ready held 1 -> ser_out = 1,0,1,0,0,1,0,1 on consecutive cycles, ser_last high on the 8th only, then IDLE.
REQ-035 LSB_FIRST = 0, in_data = 8'h81 -> ser_out = 1,0,0,0,0,0,0,1; sel sequence = 7,6,...,0.
REQ-036 Backpressure: ser_ready = 0 for 3 cycles while cnt = 2 -> ser_out and sel hold for 3 cycles; frame completes with the correct 8 bits in 11 cycles.
REQ-037 GAP = 0, bytes 8'h0F then 8'hF0 with in_valid held -> 16 contiguous ser_valid cycles, in_ready pulses on the first ser_last cycle.
REQ-038 GAP = 3, two bytes queued -> exactly 3 cycles with ser_valid = 0 and in_ready = 0 between the frames.
REQ-039 rst_n = 0 for 1 cycle at cnt = 4 -> next cycle in_ready = 1, ser_valid = 0, busy = 0; the next byte is sent from its bit 0 intact.
